// File: rtl/dcache_assoc_pkg.sv
// dcache_assoc shared types: FSM encodings, uncached region, helpers.
// Field widths derive from the BLK_LEN/SETS parameters in each module.
package dcache_assoc_pkg;

  typedef enum logic [2:0] {
    R_IDLE,
    R_LOOKUP,
    R_REQ,
    R_WAIT,
    R_DONE
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_WAIT,
    W_DONE
  } wstate_e;

  localparam logic [15:0] UNCACHED_HI = 16'hFFFF;

  function automatic logic is_uncached(input logic [31:0] a);
    return a[31:16] == UNCACHED_HI;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/tag/data arrays in flops with a combinational
// lookup port, a whole-line fill port and a byte-merge port.
module dcache_way #(
  parameter int BLK_LEN = 4,
  parameter int SETS = 64,
  parameter int TAG_W = 22,
  localparam int IDX_W = $clog2(SETS),
  localparam int OFF_W = $clog2(BLK_LEN),
  localparam int LINE_W = BLK_LEN * 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  lk_idx,
  output logic              lk_valid,
  output logic [TAG_W-1:0]  lk_tag,
  output logic [LINE_W-1:0] lk_line,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              mrg_en,
  input  logic [IDX_W-1:0]  mrg_idx,
  input  logic [OFF_W-1:0]  mrg_off,
  input  logic [3:0]        mrg_be,
  input  logic [31:0]       mrg_wdata
);

  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [TAG_W-1:0]  tag_d  [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  logic [LINE_W-1:0] data_d [SETS];

  assign lk_valid = valid_q[lk_idx];
  assign lk_tag   = tag_q[lk_idx];
  assign lk_line  = data_q[lk_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_tag;
      data_d[fill_idx]  = fill_line;
    end
    if (mrg_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mrg_be[b])
          data_d[mrg_idx][32*int'(mrg_off)+8*b +: 8] =
            mrg_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tag/data contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_assoc.sv
// Set-associative write-through, no-write-allocate data cache with
// round-robin replacement, byte-merged write hits and hit/miss counters.
module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int BLK_LEN = 4,
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_n,
  input  logic [3:0]           data_ren,
  input  logic [31:0]          data_addr,
  output logic                 data_valid,
  output logic [31:0]          data_rdata,
  input  logic [3:0]           data_wen,
  input  logic [31:0]          data_wdata,
  output logic                 data_wresp,
  input  logic                 dev_wrdy,
  output logic [3:0]           dev_wen,
  output logic [31:0]          dev_waddr,
  output logic [31:0]          dev_wdata,
  input  logic                 dev_rrdy,
  output logic [3:0]           dev_ren,
  output logic [31:0]          dev_raddr,
  input  logic                 dev_rvalid,
  input  logic [BLK_LEN*32-1:0] dev_rdata,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam int OFF_W  = $clog2(BLK_LEN);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;
  localparam int LINE_W = BLK_LEN * 32;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  rstate_e rstate_q, rstate_d;
  wstate_e wstate_q, wstate_d;

  logic [31:0] raddr_q, raddr_d;
  logic [3:0]  rben_q, rben_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wben_q, wben_d;
  logic [PTR_W-1:0] ptr_q [SETS];
  logic [PTR_W-1:0] ptr_d [SETS];

  logic             r_busy, r_unc;
  logic [IDX_W-1:0] lk_idx, r_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [OFF_W-1:0] lk_off, r_off;
  logic [WAYS-1:0]  way_valid, way_hit;
  logic [TAG_W-1:0] way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];
  logic [LINE_W-1:0] hit_line;
  logic [31:0]      hit_word;
  logic             hit_any, r_accept, w_accept;
  logic             fill_go, mrg_go, r_fire, w_fire;
  logic [PTR_W-1:0] victim;

  // Lookups follow the captured read address while a read is in flight,
  // otherwise the live CPU address (used by the write-hit merge).
  assign r_busy = rstate_q != R_IDLE;
  assign r_unc  = is_uncached(raddr_q);
  assign r_idx  = raddr_q[IDX_W+OFF_W+1 -: IDX_W];
  assign r_off  = raddr_q[OFF_W+1:2];
  assign lk_idx = r_busy ? r_idx : data_addr[IDX_W+OFF_W+1 -: IDX_W];
  assign lk_tag = r_busy ? raddr_q[31 -: TAG_W] : data_addr[31 -: TAG_W];
  assign lk_off = r_busy ? r_off : data_addr[OFF_W+1:2];

  assign victim  = ptr_q[r_idx];
  assign fill_go = (rstate_q == R_WAIT) && dev_rvalid && !r_unc;
  assign r_accept = !r_busy && (wstate_q == W_IDLE) &&
                    (data_wen == 4'h0) && (data_ren != 4'h0);
  assign w_accept = (wstate_q == W_IDLE) && !r_busy &&
                    (data_wen != 4'h0);
  assign mrg_go = w_accept && !is_uncached(data_addr) && hit_any;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(
      .BLK_LEN(BLK_LEN),
      .SETS(SETS),
      .TAG_W(TAG_W)
    ) u_way (
      .clk(cpu_clk),
      .rst_n(cpu_rst_n),
      .lk_idx(lk_idx),
      .lk_valid(way_valid[w]),
      .lk_tag(way_tag[w]),
      .lk_line(way_line[w]),
      .fill_en(fill_go && (victim == PTR_W'(w))),
      .fill_idx(r_idx),
      .fill_tag(raddr_q[31 -: TAG_W]),
      .fill_line(dev_rdata),
      .mrg_en(mrg_go && way_hit[w]),
      .mrg_idx(lk_idx),
      .mrg_off(lk_off),
      .mrg_be(data_wen),
      .mrg_wdata(data_wdata)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == lk_tag);
  end

  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_line = hit_line | way_line[w];
    end
  end

  assign hit_any  = |way_hit;
  assign hit_word = hit_line[32*int'(lk_off) +: 32];

  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rben_d   = rben_q;
    rdata_d  = rdata_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    ptr_d    = ptr_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (r_accept) begin
          raddr_d  = data_addr;
          rben_d   = data_ren;
          rstate_d = R_LOOKUP;
        end
      end
      R_LOOKUP: begin
        if (r_unc) begin
          rstate_d = R_REQ;
        end else if (hit_any) begin
          rdata_d  = hit_word;
          hit_d    = sat_inc(hit_q);
          rstate_d = R_DONE;
        end else begin
          miss_d   = sat_inc(miss_q);
          rstate_d = R_REQ;
        end
      end
      R_REQ: begin
        if (dev_rrdy) rstate_d = R_WAIT;
      end
      R_WAIT: begin
        if (dev_rvalid) begin
          if (r_unc) begin
            rdata_d = dev_rdata[31:0];
          end else begin
            rdata_d = dev_rdata[32*int'(r_off) +: 32];
            ptr_d[r_idx] = (WAYS == 1) ? '0 : victim + PTR_W'(1);
          end
          rstate_d = R_DONE;
        end
      end
      R_DONE:  rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wben_d   = wben_q;
    unique case (wstate_q)
      W_IDLE: begin
        if (w_accept) begin
          waddr_d  = data_addr;
          wdata_d  = data_wdata;
          wben_d   = data_wen;
          wstate_d = W_REQ;
        end
      end
      W_REQ:   if (dev_wrdy) wstate_d = W_WAIT;
      W_WAIT:  if (dev_wrdy) wstate_d = W_DONE;
      W_DONE:  wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rstate_q <= R_IDLE;
      wstate_q <= W_IDLE;
      raddr_q  <= '0;
      rben_q   <= '0;
      rdata_q  <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wben_q   <= '0;
      ptr_q    <= '{default: '0};
    end else begin
      rstate_q <= rstate_d;
      wstate_q <= wstate_d;
      raddr_q  <= raddr_d;
      rben_q   <= rben_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wben_q   <= wben_d;
      ptr_q    <= ptr_d;
    end
  end

  // Bus strobes are combinational from state so a reset drops them at once.
  assign r_fire    = (rstate_q == R_REQ) && dev_rrdy;
  assign w_fire    = (wstate_q == W_REQ) && dev_wrdy;
  assign dev_ren   = !r_fire ? 4'h0 : (r_unc ? rben_q : 4'hF);
  assign dev_raddr = !r_fire ? 32'h0 :
                     r_unc ? raddr_q :
                     {raddr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign dev_wen   = w_fire ? wben_q : 4'h0;
  assign dev_waddr = w_fire ? waddr_q : 32'h0;
  assign dev_wdata = w_fire ? wdata_q : 32'h0;

  assign data_valid = rstate_q == R_DONE;
  assign data_rdata = rdata_q;
  assign data_wresp = wstate_q == W_DONE;
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: directed reads/writes against a
// memory model, with a negedge monitor popping expected responses.
module tb_dcache_assoc;

  localparam int KHIT = 0;
  localparam int KMISS = 1;
  localparam int KUNC = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   data_ren;
  logic [31:0]  data_addr;
  logic         data_valid;
  logic [31:0]  data_rdata;
  logic [3:0]   data_wen;
  logic [31:0]  data_wdata;
  logic         data_wresp;
  logic         dev_wrdy;
  logic [3:0]   dev_wen;
  logic [31:0]  dev_waddr;
  logic [31:0]  dev_wdata;
  logic         dev_rrdy;
  logic [3:0]   dev_ren;
  logic [31:0]  dev_raddr;
  logic         dev_rvalid;
  logic [127:0] dev_rdata;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  dcache_assoc #(.BLK_LEN(4), .SETS(64), .WAYS(2)) dut (
    .cpu_clk(clk),
    .cpu_rst_n(rst_n),
    .data_ren(data_ren),
    .data_addr(data_addr),
    .data_valid(data_valid),
    .data_rdata(data_rdata),
    .data_wen(data_wen),
    .data_wdata(data_wdata),
    .data_wresp(data_wresp),
    .dev_wrdy(dev_wrdy),
    .dev_wen(dev_wen),
    .dev_waddr(dev_waddr),
    .dev_wdata(dev_wdata),
    .dev_rrdy(dev_rrdy),
    .dev_ren(dev_ren),
    .dev_raddr(dev_raddr),
    .dev_rvalid(dev_rvalid),
    .dev_rdata(dev_rdata),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q_rd[$];
  logic [35:0] q_dev[$];
  logic [67:0] q_devw[$];
  logic [31:0] q_wr[$];
  logic [31:0] mem [logic [31:0]];

  int exp_hit = 0;
  int exp_miss = 0;
  int dren_cyc = 0;
  int wresp_cyc = 0;
  int last_c0 = 0;
  int rgen = 0;
  int rdelay = 1;
  bit spur_req = 1'b0;
  int stall_start = 0;

  task automatic chk(input string name, input logic [67:0] act,
                     input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hD00D_0000;
  endfunction

  // Monitor: pops expectations whenever the DUT presents something.
  initial begin : monitor
    logic pv, pw;
    logic [31:0] w, wa;
    pv = 1'b0;
    pw = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) begin
        chk("valid_pulse", 68'(pv), 68'(0));
        if (q_rd.size() == 0) chk("rd_unexpected", 68'(1), 68'(0));
        else chk("rdata", 68'(data_rdata), 68'(q_rd.pop_front()));
      end
      if (data_wresp) begin
        wresp_cyc = cyc;
        chk("wresp_pulse", 68'(pw), 68'(0));
        if (q_wr.size() == 0) chk("wr_unexpected", 68'(1), 68'(0));
        else void'(q_wr.pop_front());
      end
      if (dev_ren != 4'h0) begin
        dren_cyc = cyc;
        chk("ren_with_rrdy", 68'(dev_rrdy), 68'(1));
        if (q_dev.size() == 0)
          chk("dev_rd_unexpected", 68'({dev_ren, dev_raddr}), 68'(0));
        else chk("dev_rd", 68'({dev_ren, dev_raddr}), 68'(q_dev.pop_front()));
      end
      if (dev_wen != 4'h0) begin
        chk("wen_with_wrdy", 68'(dev_wrdy), 68'(1));
        if (q_devw.size() == 0)
          chk("dev_wr_unexpected", 68'(dev_waddr), 68'(0));
        else
          chk("dev_wr", {dev_wen, dev_waddr, dev_wdata}, q_devw.pop_front());
        wa = {dev_waddr[31:2], 2'b00};
        w = memrd(wa);
        for (int b = 0; b < 4; b++)
          if (dev_wen[b]) w[8*b +: 8] = dev_wdata[8*b +: 8];
        mem[wa] = w;
      end
      pv = data_valid;
      pw = data_wresp;
    end
  end

  // Memory read responder; a reset bumps rgen to cancel a pending reply.
  initial begin : responder
    logic [31:0] a, base;
    int g;
    dev_rvalid = 1'b0;
    dev_rdata = '0;
    forever begin
      @(negedge clk);
      if (spur_req) begin
        spur_req = 1'b0;
        @(posedge clk);
        #1;
        dev_rdata = '1;
        dev_rvalid = 1'b1;
        @(posedge clk);
        #1;
        dev_rvalid = 1'b0;
      end else if (dev_ren != 4'h0) begin
        a = dev_raddr;
        g = rgen;
        repeat (rdelay) @(posedge clk);
        #1;
        if (g == rgen) begin
          base = (a[31:16] == 16'hFFFF) ? {a[31:2], 2'b00} : {a[31:4], 4'h0};
          for (int i = 0; i < 4; i++)
            dev_rdata[32*i +: 32] = memrd(base + 32'(4 * i));
          dev_rvalid = 1'b1;
          @(posedge clk);
          #1;
          dev_rvalid = 1'b0;
        end
      end
    end
  end

  task automatic cpu_read(input logic [31:0] addr, input logic [3:0] ren,
                          input int kind, input logic [31:0] exp,
                          input string name);
    bit got;
    @(posedge clk);
    #1;
    if (kind == KUNC) q_dev.push_back({ren, addr});
    else if (kind == KMISS) q_dev.push_back({4'hF, addr[31:4], 4'h0});
    if (kind == KHIT) exp_hit++;
    if (kind == KMISS) exp_miss++;
    q_rd.push_back(exp);
    data_addr = addr;
    data_ren = ren;
    last_c0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (data_valid) got = 1'b1;
    end
    data_ren = 4'h0;
    if (!got) begin
      chk({name, "_timeout"}, 68'(0), 68'(1));
    end else begin
      if (kind == KHIT) chk({name, "_lat"}, 68'(cyc - last_c0), 68'(2));
      chk({name, "_hitcnt"}, 68'(hit_cnt), 68'(exp_hit));
      chk({name, "_misscnt"}, 68'(miss_cnt), 68'(exp_miss));
    end
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [3:0] wen,
                           input logic [31:0] wd, input string name);
    bit got;
    int c0;
    @(posedge clk);
    #1;
    q_devw.push_back({wen, addr, wd});
    q_wr.push_back(addr);
    data_addr = addr;
    data_wen = wen;
    data_wdata = wd;
    c0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (data_wresp) got = 1'b1;
    end
    data_wen = 4'h0;
    if (!got) chk({name, "_timeout"}, 68'(0), 68'(1));
    else chk({name, "_lat_ge3"}, 68'((cyc - c0) >= 3), 68'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    data_ren = 4'h0;
    data_addr = 32'h0;
    data_wen = 4'h0;
    data_wdata = 32'h0;
    dev_rrdy = 1'b1;
    dev_wrdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_out", 68'({data_valid, data_rdata}), 68'(0));
    chk("rst_wresp", 68'(data_wresp), 68'(0));
    chk("rst_dev_w", 68'({dev_wen, dev_waddr, dev_wdata}), 68'(0));
    chk("rst_dev_r", 68'({dev_ren, dev_raddr}), 68'(0));
    chk("rst_cnts", 68'({hit_cnt, miss_cnt}), 68'(0));
    rst_n = 1'b1;

    cpu_read(32'h10, 4'hF, KMISS, 32'hD00D_0010, "cold_0x10");
    chk("miss_ren_lat", 68'(dren_cyc - last_c0), 68'(2));
    cpu_read(32'h14, 4'hF, KHIT, 32'hD00D_0014, "hit_0x14");

    cpu_read(32'h000, 4'hF, KMISS, 32'hD00D_0000, "set0_a");
    cpu_read(32'h400, 4'hF, KMISS, 32'hD00D_0400, "set0_b");
    cpu_read(32'h800, 4'hF, KMISS, 32'hD00D_0800, "set0_c");
    cpu_read(32'h000, 4'hF, KMISS, 32'hD00D_0000, "set0_a_evicted");
    spur_req = 1'b1;
    repeat (4) @(posedge clk);
    cpu_read(32'h800, 4'hF, KHIT, 32'hD00D_0800, "set0_c_hit");

    cpu_write(32'h14, 4'b0011, 32'hAAAA_BBBB, "wr_0x14");
    cpu_read(32'h14, 4'hF, KHIT, 32'hD00D_BBBB, "merged_0x14");

    cpu_read(32'hFFFF_0004, 4'h1, KUNC, 32'h2FF2_0004, "unc_a");
    cpu_read(32'hFFFF_0004, 4'h1, KUNC, 32'h2FF2_0004, "unc_again");

    dev_rrdy = 1'b0;
    stall_start = cyc;
    fork
      begin
        repeat (6) @(posedge clk);
        #2 dev_rrdy = 1'b1;
      end
      cpu_read(32'h20, 4'hF, KMISS, 32'hD00D_0020, "stall_rd");
    join
    chk("stall_ren_late", 68'(dren_cyc >= stall_start + 6), 68'(1));
    dev_wrdy = 1'b0;
    stall_start = cyc;
    fork
      begin
        repeat (6) @(posedge clk);
        #2 dev_wrdy = 1'b1;
      end
      cpu_write(32'h18, 4'b1100, 32'h5555_6666, "stall_wr");
    join
    chk("stall_wresp_late", 68'(wresp_cyc >= stall_start + 8), 68'(1));
    cpu_read(32'h18, 4'hF, KHIT, 32'h5555_0018, "merged_0x18");

    fork
      cpu_write(32'h44, 4'hF, 32'h1234_5678, "sim_wr");
      cpu_read(32'h44, 4'hF, KMISS, 32'h1234_5678, "sim_rd");
    join
    chk("write_before_ren", 68'(dren_cyc > wresp_cyc), 68'(1));

    rdelay = 20;
    @(posedge clk);
    #1;
    q_dev.push_back({4'hF, 32'h60});
    data_addr = 32'h60;
    data_ren = 4'hF;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_dev_r", 68'({dev_ren, dev_raddr}), 68'(0));
    chk("mid_rst_rd_out", 68'({data_valid, data_rdata}), 68'(0));
    chk("mid_rst_cnts", 68'({hit_cnt, miss_cnt}), 68'(0));
    data_ren = 4'h0;
    rgen++;
    exp_hit = 0;
    exp_miss = 0;
    rdelay = 1;
    repeat (25) @(negedge clk);
    rst_n = 1'b1;
    cpu_read(32'h10, 4'hF, KMISS, 32'hD00D_0010, "post_rst_0x10");

    repeat (5) @(negedge clk);
    chk("q_rd_empty", 68'(q_rd.size()), 68'(0));
    chk("q_dev_empty", 68'(q_dev.size()), 68'(0));
    chk("q_devw_empty", 68'(q_devw.size()), 68'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
